// File: rtl/dp_multicycle_ctrl.sv
// Multicycle control FSM (IDLE/DECODE/EXEC/MEM/WB) for the regfile/ALU/data-memory datapath.
// Optional CTRL_PERF_CNT_EN adds retired_cnt/trap_cnt performance counters.
module dp_multicycle_ctrl #(
  parameter logic [3:0] ALU_AND = 4'b0000,
  parameter logic [3:0] ALU_OR  = 4'b0001,
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0110,
  parameter logic [3:0] ALU_SLT = 4'b0111,
  parameter logic [3:0] ALU_NOR = 4'b1100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr_in,
  output logic [25:0] Instruction,
  output logic        RegDst,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic [3:0]  ALUControl_Signal,
  input  logic        zero,
  input  logic        overflow,
  output logic        busy,
  output logic        done,
  output logic        branch_taken,
  output logic        illegal,
  output logic        ovf_trap
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [15:0] trap_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

  state_t      state_reg, state_next;
  logic [31:0] ir_reg;
  logic        ovf_reg;

  logic [5:0] opcode, funct;
  logic       funct_ok, is_rtype, is_addi, is_lw, is_sw, is_beq, legal, ovf_op;
  logic [3:0] r_alu;

  assign opcode      = ir_reg[31:26];
  assign funct       = ir_reg[5:0];
  assign Instruction = ir_reg[25:0];

  always_comb begin
    funct_ok = 1'b1;
    r_alu    = ALU_ADD;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      6'b100111: r_alu = ALU_NOR;
      default:   funct_ok = 1'b0;
    endcase
  end

  assign is_rtype = (opcode == 6'b000000) && funct_ok;
  assign is_addi  = (opcode == 6'b001000);
  assign is_lw    = (opcode == 6'b100011);
  assign is_sw    = (opcode == 6'b101011);
  assign is_beq   = (opcode == 6'b000100);
  assign legal    = is_rtype || is_addi || is_lw || is_sw || is_beq;
  // Only signed-arithmetic instructions can trap on overflow.
  assign ovf_op   = (is_rtype && (funct == 6'b100000 || funct == 6'b100010)) || is_addi;

  always_comb begin
    state_next        = state_reg;
    RegDst            = 1'b0;
    MemRead           = 1'b0;
    MemWrite          = 1'b0;
    MemToReg          = 1'b0;
    ALUSrc            = 1'b0;
    RegWrite          = 1'b0;
    ALUControl_Signal = 4'b0000;
    done              = 1'b0;
    illegal           = 1'b0;
    ovf_trap          = 1'b0;
    case (state_reg)
      IDLE: begin
        ALUControl_Signal = ALU_ADD;
        if (instr_valid) state_next = DECODE;
      end
      DECODE: begin
        if (legal) begin
          state_next = EXEC;
        end else begin
          illegal    = 1'b1;
          state_next = IDLE;
        end
      end
      EXEC: begin
        if (is_rtype) begin
          RegDst            = 1'b1;
          ALUControl_Signal = r_alu;
          state_next        = WB;
        end else if (is_beq) begin
          ALUControl_Signal = ALU_SUB;
          done              = 1'b1;
          state_next        = IDLE;
        end else begin
          ALUSrc            = 1'b1;
          ALUControl_Signal = ALU_ADD;
          state_next        = (is_lw || is_sw) ? MEM : WB;
        end
      end
      MEM: begin
        ALUSrc            = 1'b1;
        ALUControl_Signal = ALU_ADD;
        if (is_lw) begin
          MemRead    = 1'b1;
          state_next = WB;
        end else begin
          MemWrite   = 1'b1;
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      WB: begin
        done       = 1'b1;
        RegWrite   = !ovf_reg;
        ovf_trap   = ovf_reg;
        state_next = IDLE;
        if (is_rtype) begin
          RegDst            = 1'b1;
          ALUControl_Signal = r_alu;
          MemToReg          = 1'b1;
        end else if (is_addi) begin
          ALUSrc            = 1'b1;
          ALUControl_Signal = ALU_ADD;
          MemToReg          = 1'b1;
        end else begin
          ALUSrc            = 1'b1;
          ALUControl_Signal = ALU_ADD;
          MemRead           = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Reset overrides the current state so no write can escape in the reset cycle.
    if (reset) begin
      state_next        = IDLE;
      RegDst            = 1'b0;
      MemRead           = 1'b0;
      MemWrite          = 1'b0;
      MemToReg          = 1'b0;
      ALUSrc            = 1'b0;
      RegWrite          = 1'b0;
      ALUControl_Signal = 4'b0000;
      done              = 1'b0;
      illegal           = 1'b0;
      ovf_trap          = 1'b0;
    end
  end

  assign instr_ready = (state_reg == IDLE) && !reset;
  assign busy        = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      ir_reg       <= 32'd0;
      branch_taken <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && instr_valid) begin
        ir_reg       <= instr_in;
        branch_taken <= 1'b0;
        ovf_reg      <= 1'b0;
      end
      if (state_reg == EXEC) begin
        if (is_beq) branch_taken <= zero;
        if (ovf_op) ovf_reg <= overflow;
      end
    end
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= 32'd0;
      trap_cnt    <= 16'd0;
    end else begin
      if (done) retired_cnt <= retired_cnt + 32'd1;
      if (illegal || ovf_trap) trap_cnt <= trap_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dp_multicycle_ctrl.sv
// Self-checking bench for dp_multicycle_ctrl: directed plus random instructions against
// an instruction-level phase model; counters checked when CTRL_PERF_CNT_EN is defined.
module tb_dp_multicycle_ctrl;
  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110, A_SLT = 4'b0111, A_NOR = 4'b1100;
  localparam int C_R = 0, C_ADDI = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_ILL = 5;
  localparam int P_DEC = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4;

  logic        clk = 1'b0, reset = 1'b1, instr_valid = 1'b0, zero = 1'b0, overflow = 1'b0;
  logic [31:0] instr_in = 32'd0;
  logic        instr_ready, RegDst, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite;
  logic [25:0] Instruction;
  logic [3:0]  ALUControl_Signal;
  logic        busy, done, branch_taken, illegal, ovf_trap;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [15:0] trap_cnt;
`endif

  int          errors = 0, checks = 0;
  logic [31:0] ir_model = 32'd0;
  logic        bt_model = 1'b0;
  logic [31:0] ret_model = 32'd0;
  logic [15:0] trap_model = 16'd0;
  logic [5:0]  fn_tab[6];

  dp_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_in(instr_in), .Instruction(Instruction), .RegDst(RegDst), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .ALUControl_Signal(ALUControl_Signal), .zero(zero), .overflow(overflow), .busy(busy),
    .done(done), .branch_taken(branch_taken), .illegal(illegal), .ovf_trap(ovf_trap)
`ifdef CTRL_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .trap_cnt(trap_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] obs_vec();
    return {RegDst, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite, ALUControl_Signal,
            busy, done, illegal, ovf_trap, instr_ready, branch_taken};
  endfunction

  function automatic logic [15:0] mk(input logic rd, mr, mw, m2r, as, rw, input logic [3:0] alu,
                                     input logic bsy, dn, ill, ovt, rdy, bt);
    return {rd, mr, mw, m2r, as, rw, alu, bsy, dn, ill, ovt, rdy, bt};
  endfunction

  function automatic logic [15:0] idle_vec(input logic bt);
    return mk(0, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0, 0, 1, bt);
  endfunction

  function automatic int cls_of(input logic [31:0] w);
    int c;
    c = C_ILL;
    if (w[31:26] == 6'h00) begin
      if (w[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27}) c = C_R;
    end else if (w[31:26] == 6'h08) c = C_ADDI;
    else if (w[31:26] == 6'h23) c = C_LW;
    else if (w[31:26] == 6'h2B) c = C_SW;
    else if (w[31:26] == 6'h04) c = C_BEQ;
    return c;
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    logic [3:0] a;
    case (fn)
      6'h20: a = A_ADD;
      6'h22: a = A_SUB;
      6'h24: a = A_AND;
      6'h25: a = A_OR;
      6'h2A: a = A_SLT;
      6'h27: a = A_NOR;
      default: a = A_AND;
    endcase
    return a;
  endfunction

  // Expected outputs for one phase of an instruction, straight from the control table.
  function automatic logic [15:0] exp_phase(input int cls, input logic [3:0] ar, input int ph,
                                            input logic ovf);
    logic rd, mr, mw, m2r, as, rw, dn, ill, ovt;
    logic [3:0] alu;
    {rd, mr, mw, m2r, as, rw, dn, ill, ovt} = 9'd0;
    alu = 4'b0000;
    case (ph)
      P_DEC: ill = (cls == C_ILL);
      P_EXEC: begin
        if (cls == C_R) begin rd = 1; alu = ar; end
        else if (cls == C_BEQ) begin alu = A_SUB; dn = 1; end
        else begin as = 1; alu = A_ADD; end
      end
      P_MEM: begin
        as = 1; alu = A_ADD;
        if (cls == C_LW) mr = 1;
        else begin mw = 1; dn = 1; end
      end
      default: begin
        dn = 1; rw = !ovf; ovt = ovf;
        if (cls == C_R) begin rd = 1; alu = ar; m2r = 1; end
        else if (cls == C_ADDI) begin as = 1; alu = A_ADD; m2r = 1; end
        else begin as = 1; alu = A_ADD; mr = 1; end
      end
    endcase
    return mk(rd, mr, mw, m2r, as, rw, alu, 1, dn, ill, ovt, 0, 0);
  endfunction

  // zmode/omode: 0 or 1 force the EXEC-cycle flag, 2 leaves it random.
  // abort_at: phase index (1-based) at which reset is asserted, 0 for none.
  task automatic run_instr(input logic [31:0] w, input int zmode, input int omode, input int abort_at);
    int cls;
    logic [3:0] ar;
    int ph[$];
    logic z_e, o_e, ovf_cap;
    cls = cls_of(w);
    ar  = alu_of(w[5:0]);
    chk("idle_vec", {16'd0, obs_vec()}, {16'd0, idle_vec(bt_model)});
    chk("idle_instr", {6'd0, Instruction}, {6'd0, ir_model[25:0]});
    instr_valid = 1'b1;
    instr_in    = w;
    zero        = 1'($urandom);
    overflow    = 1'($urandom);
    @(posedge clk);
    ir_model = w;
    bt_model = 1'b0;
    z_e = 1'b0;
    o_e = 1'b0;
    ph = {P_DEC};
    if (cls != C_ILL) ph.push_back(P_EXEC);
    if (cls == C_LW || cls == C_SW) ph.push_back(P_MEM);
    if (cls == C_R || cls == C_ADDI || cls == C_LW) ph.push_back(P_WB);
    foreach (ph[k]) begin
      @(negedge clk);
      instr_valid = 1'($urandom);
      instr_in    = $urandom;
      zero        = 1'($urandom);
      overflow    = 1'($urandom);
      if (ph[k] == P_EXEC) begin
        if (zmode < 2) zero = zmode[0];
        if (omode < 2) overflow = omode[0];
        z_e = zero;
        o_e = overflow;
      end
      if (k + 1 == abort_at) begin
        reset = 1'b1;
        #1;
        chk("rst_cycle_vec", {16'd0, obs_vec()}, {16'd0, mk(0, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0)});
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        instr_valid = 1'b0;
        ir_model = 32'd0;
        bt_model = 1'b0;
        ret_model = 32'd0;
        trap_model = 16'd0;
        #1;
        $display("txn %h class=%0d aborted by reset in phase %0d", w, cls, k + 1);
        return;
      end
      #1;
      ovf_cap = o_e && ((cls == C_R && (w[5:0] == 6'h20 || w[5:0] == 6'h22)) || cls == C_ADDI);
      chk($sformatf("phase%0d_vec", k + 1), {16'd0, obs_vec()}, {16'd0, exp_phase(cls, ar, ph[k], ovf_cap)});
      chk("hold_instr", {6'd0, Instruction}, {6'd0, w[25:0]});
    end
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    if (cls == C_BEQ) bt_model = z_e;
    if (cls != C_ILL) ret_model = ret_model + 32'd1;
    if (cls == C_ILL || ovf_cap) trap_model = trap_model + 16'd1;
    $display("txn %h class=%0d cycles=%0d branch=%0b", w, cls, ph.size() + 1, bt_model);
  endtask

  initial begin
    logic [31:0] w;
    int sel;
    fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24;
    fn_tab[3] = 6'h25; fn_tab[4] = 6'h2A; fn_tab[5] = 6'h27;

    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_vec", {16'd0, obs_vec()}, 32'd0);
    chk("reset_instr", {6'd0, Instruction}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_idle", {16'd0, obs_vec()}, {16'd0, idle_vec(1'b0)});
    @(negedge clk);

    run_instr(32'h00221820, 2, 0, 0);   // add, no overflow
    run_instr(32'h8C050008, 2, 2, 0);   // lw
    run_instr(32'hAC050004, 2, 2, 0);   // sw
    run_instr(32'h10220003, 1, 2, 0);   // beq taken
    run_instr(32'h00221820, 2, 1, 0);   // add with overflow trap
    run_instr(32'hFC000000, 2, 2, 0);   // illegal opcode
    run_instr(32'h10220003, 0, 2, 0);   // beq not taken
    run_instr(32'h00221822, 2, 1, 0);   // sub with overflow
    run_instr(32'h2021FFFF, 2, 1, 0);   // addi with overflow
    run_instr(32'h0022182A, 2, 1, 0);   // slt ignores overflow
    run_instr(32'h00000001, 2, 2, 0);   // bad funct

    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      sel = $urandom_range(0, 6);
      case (sel)
        0: begin w[31:26] = 6'h00; w[5:0] = fn_tab[$urandom_range(0, 5)]; end
        1: w[31:26] = 6'h08;
        2: w[31:26] = 6'h23;
        3: w[31:26] = 6'h2B;
        4: w[31:26] = 6'h04;
        5: w[31:26] = 6'h00;
        default: ;
      endcase
      run_instr(w, 2, 2, 0);
    end

`ifdef CTRL_PERF_CNT_EN
    chk("retired_cnt", retired_cnt, ret_model);
    chk("trap_cnt", {16'd0, trap_cnt}, {16'd0, trap_model});
`endif
    run_instr(32'hAC050004, 2, 2, 3);   // reset during MEM of sw
    run_instr(32'h00221820, 2, 0, 0);
    chk("final_idle", {16'd0, obs_vec()}, {16'd0, idle_vec(bt_model)});
`ifdef CTRL_PERF_CNT_EN
    chk("retired_cnt_after_reset", retired_cnt, ret_model);
    chk("trap_cnt_after_reset", {16'd0, trap_cnt}, {16'd0, trap_model});
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
